smi_rx_unpacker: RTL and testbench

Downstream consumer of the LVDS receive FIFO. It pops 32-bit sample words from the RX FIFO and serves each word to the host as four bytes over the 8-bit SMI read bus, most significant byte first. Each byte is paced by the host's active-low read strobe. The block runs in the system clock domain on the FIFO read side; the strobe arrives asynchronously and is synchronized internally.

---
 rtl/smi_rx_unpacker.sv | 153 +++++++++++++++
 tb/tb_smi_rx_unpacker.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/smi_rx_unpacker.sv
// -----------------------------------------------------------------------------
// smi_rx_unpacker
//
// Pops 32-bit sample words from the LVDS RX FIFO and serves each word to the
// host as four bytes on the 8-bit SMI read bus, most significant byte first.
// Each byte is advanced by the rising edge (end of read) of the host's
// active-low read strobe, which is synchronized into i_clk here.
//
// Optional build macro:
//   SMI_RX_UNDERRUN_EN - when defined, o_underrun latches high on any strobe
//                        rising edge seen while no word is being served.
//                        When undefined, o_underrun is tied low.
//
// Ports:
//   i_clk         system clock (FIFO read side)
//   i_reset       synchronous, active-high reset
//   i_enable      allows new words to be pulled; the in-flight word completes
//   i_fifo_empty  RX FIFO empty flag
//   o_fifo_pull   single-cycle FIFO read request
//   i_fifo_data   FIFO read data, valid the cycle after o_fifo_pull
//   i_smi_soe_n   host read strobe, active-low, asynchronous
//   o_smi_data    byte presented to the host
//   o_data_ready  high while a loaded word has bytes remaining
//   o_underrun    sticky strobe-without-data flag
// -----------------------------------------------------------------------------
module smi_rx_unpacker #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic        i_fifo_empty,
  output logic        o_fifo_pull,
  input  logic [31:0] i_fifo_data,
  input  logic        i_smi_soe_n,
  output logic [7:0]  o_smi_data,
  output logic        o_data_ready,
  output logic        o_underrun
);

  typedef enum logic [1:0] {
    IDLE,
    PULL,
    LOAD,
    SERVE
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] soe_sync;
  logic                   soe_prev;
  logic                   soe_rise;
  logic                   start_word;
  logic [31:0]            word;
  logic [1:0]             idx;

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
    logic [7:0] b;
    case (i)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  // Synchronizer and edge detector reset to the strobe's idle-high level so
  // that releasing reset never produces a spurious rising edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      soe_sync <= '1;
      soe_prev <= 1'b1;
    end else begin
      soe_sync <= {soe_sync[SYNC_STAGES-2:0], i_smi_soe_n};
      soe_prev <= soe_sync[SYNC_STAGES-1];
    end
  end

  assign soe_rise   = soe_sync[SYNC_STAGES-1] & ~soe_prev;
  assign start_word = i_enable & ~i_fifo_empty;

  // Word sequencing. o_fifo_pull is only raised on entry to PULL and is
  // cleared every other cycle, so it can never be high two cycles running.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= IDLE;
      idx          <= 2'd0;
      word         <= 32'h0;
      o_fifo_pull  <= 1'b0;
      o_smi_data   <= 8'h00;
      o_data_ready <= 1'b0;
    end else begin
      o_fifo_pull <= 1'b0;
      case (state)
        IDLE: begin
          o_smi_data   <= 8'h00;
          o_data_ready <= 1'b0;
          if (start_word) begin
            state       <= PULL;
            o_fifo_pull <= 1'b1;
          end
        end
        PULL: begin
          state <= LOAD;
        end
        LOAD: begin
          word         <= i_fifo_data;
          idx          <= 2'd0;
          o_smi_data   <= i_fifo_data[31:24];
          o_data_ready <= 1'b1;
          state        <= SERVE;
        end
        SERVE: begin
          if (soe_rise) begin
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
              // Last byte consumed: chain straight into the next word if
              // allowed, otherwise park with the bus cleared.
              o_data_ready <= 1'b0;
              if (start_word) begin
                state       <= PULL;
                o_fifo_pull <= 1'b1;
              end else begin
                state      <= IDLE;
                o_smi_data <= 8'h00;
              end
            end else begin
              o_smi_data <= byte_sel(word, idx + 2'd1);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef SMI_RX_UNDERRUN_EN
  // Any completed host read while no word is being served means the host
  // consumed a byte that never existed; remember it until reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_underrun <= 1'b0;
    end else if (soe_rise && (state != SERVE)) begin
      o_underrun <= 1'b1;
    end
  end
`else
  assign o_underrun = 1'b0;
`endif

endmodule

// File: tb/tb_smi_rx_unpacker.sv
// -----------------------------------------------------------------------------
// tb_smi_rx_unpacker
//
// Self-checking bench for smi_rx_unpacker. A queue models the RX FIFO and a
// second queue holds the bytes the host should see (each pushed word expanded
// MSB first). The host strobe is driven with randomized low/high times.
// -----------------------------------------------------------------------------
module tb_smi_rx_unpacker;

  localparam int SYNC_STAGES = 2;

`ifdef SMI_RX_UNDERRUN_EN
  localparam logic EXP_UNDERRUN = 1'b1;
`else
  localparam logic EXP_UNDERRUN = 1'b0;
`endif

  logic        i_clk        = 1'b0;
  logic        i_reset      = 1'b1;
  logic        i_enable     = 1'b0;
  logic        i_fifo_empty = 1'b1;
  logic [31:0] i_fifo_data  = 32'h0;
  logic        i_smi_soe_n  = 1'b1;
  logic        o_fifo_pull;
  logic [7:0]  o_smi_data;
  logic        o_data_ready;
  logic        o_underrun;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] fifo_q[$];
  logic [7:0]  exp_q[$];

  int   pull_count     = 0;
  int   pull_empty_err = 0;
  int   pull_b2b_err   = 0;
  logic prev_pull      = 1'b0;
  int   low_run        = 0;
  int   last_gap       = 0;

  smi_rx_unpacker #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_enable     (i_enable),
    .i_fifo_empty (i_fifo_empty),
    .o_fifo_pull  (o_fifo_pull),
    .i_fifo_data  (i_fifo_data),
    .i_smi_soe_n  (i_smi_soe_n),
    .o_smi_data   (o_smi_data),
    .o_data_ready (o_data_ready),
    .o_underrun   (o_underrun)
  );

  always #5 i_clk = ~i_clk;

  // FIFO model: a pull seen on this edge returns data for the next cycle.
  always @(posedge i_clk) begin
    if (o_fifo_pull === 1'b1) begin
      pull_count++;
      if (prev_pull) pull_b2b_err++;
      if (fifo_q.size() == 0) pull_empty_err++;
      else i_fifo_data <= fifo_q.pop_front();
    end
    prev_pull = (o_fifo_pull === 1'b1);
  end

  // Empty flag refresh and measurement of o_data_ready low gaps.
  always @(negedge i_clk) begin
    i_fifo_empty = (fifo_q.size() == 0);
    if (o_data_ready === 1'b1) begin
      if (low_run > 0) last_gap = low_run;
      low_run = 0;
    end else begin
      low_run++;
    end
  end

  task automatic push_word(input logic [31:0] w);
    fifo_q.push_back(w);
    for (int b = 3; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
  endtask

  function automatic logic [7:0] next_exp();
    if (exp_q.size() == 0) return 8'hxx;
    return exp_q.pop_front();
  endfunction

  // One host read: wait (bounded) for data, pull strobe low, sample the byte
  // while low, release strobe and hold it high.
  task automatic applyStimulus(input int low_cyc, input int high_cyc,
                               output logic [7:0] got, output logic rdy);
    int waited = 0;
    while (o_data_ready !== 1'b1 && waited < 40) begin
      @(negedge i_clk);
      waited++;
    end
    rdy = o_data_ready;
    i_smi_soe_n = 1'b0;
    repeat (low_cyc) @(negedge i_clk);
    got = o_smi_data;
    i_smi_soe_n = 1'b1;
    repeat (high_cyc) @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_reset  = 1'b1;
    i_enable = 1'b1;
    push_word(32'hA1B2C3D4);
    repeat (4) begin
      @(negedge i_clk);
      n_cmp++;
      if (o_fifo_pull !== 1'b0 || o_smi_data !== 8'h00 || o_data_ready !== 1'b0 || o_underrun !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL reset_outputs: got pull=%b data=%h ready=%b underrun=%b, expected all 0",
                 o_fifo_pull, o_smi_data, o_data_ready, o_underrun);
      end
    end
    i_reset = 1'b0;
    @(negedge i_clk);
    n_cmp++;
    if (o_fifo_pull !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL first_pull: got pull=%b, expected 1", o_fifo_pull);
    end
    @(negedge i_clk);
    n_cmp++;
    if (o_fifo_pull !== 1'b0 || o_data_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL pull_load_cycle: got pull=%b ready=%b, expected 0 0", o_fifo_pull, o_data_ready);
    end
    @(negedge i_clk);
    n_cmp++;
    if (o_data_ready !== 1'b1 || o_smi_data !== 8'hA1) begin
      n_fail++;
      $display("[TB] FAIL word_start: got ready=%b data=%h, expected 1 a1", o_data_ready, o_smi_data);
    end
  endtask

  task automatic test_single_word();
    logic [7:0] got, exp_byte;
    logic rdy;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(2, 6, got, rdy);
      exp_byte = next_exp();
      n_cmp++;
      if (rdy !== 1'b1 || got !== exp_byte) begin
        n_fail++;
        $display("[TB] FAIL single_byte%0d: got %h ready=%b, expected %h ready=1", k, got, rdy, exp_byte);
      end
    end
    repeat (8) @(negedge i_clk);
    n_cmp++;
    if (o_data_ready !== 1'b0 || o_smi_data !== 8'h00 || pull_count !== 1) begin
      n_fail++;
      $display("[TB] FAIL single_idle: got ready=%b data=%h pulls=%0d, expected 0 00 1",
               o_data_ready, o_smi_data, pull_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got, exp_byte;
    logic rdy;
    int base = pull_count;
    push_word(32'h01234567);
    push_word(32'h89ABCDEF);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(2, 6, got, rdy);
      exp_byte = next_exp();
      n_cmp++;
      if (rdy !== 1'b1 || got !== exp_byte) begin
        n_fail++;
        $display("[TB] FAIL b2b_byte%0d: got %h ready=%b, expected %h ready=1", k, got, rdy, exp_byte);
      end
    end
    repeat (8) @(negedge i_clk);
    n_cmp++;
    if (last_gap !== 2) begin
      n_fail++;
      $display("[TB] FAIL b2b_gap: got %0d cycles ready low, expected 2", last_gap);
    end
    n_cmp++;
    if (pull_count - base !== 2 || pull_b2b_err !== 0 || o_data_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL b2b_pulls: got pulls=%0d consecutive=%0d ready=%b, expected 2 0 0",
               pull_count - base, pull_b2b_err, o_data_ready);
    end
  endtask

  task automatic test_underrun();
    logic [7:0] got, exp_byte;
    logic rdy;
    applyStimulus(2, 6, got, rdy);
    repeat (4) @(negedge i_clk);
    n_cmp++;
    if (o_underrun !== EXP_UNDERRUN || o_smi_data !== 8'h00 || got !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL underrun_set: got underrun=%b data=%h read=%h, expected %b 00 00",
               o_underrun, o_smi_data, got, EXP_UNDERRUN);
    end
    push_word($urandom);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(2, 6, got, rdy);
      exp_byte = next_exp();
      n_cmp++;
      if (rdy !== 1'b1 || got !== exp_byte) begin
        n_fail++;
        $display("[TB] FAIL underrun_word_byte%0d: got %h ready=%b, expected %h ready=1", k, got, rdy, exp_byte);
      end
    end
    n_cmp++;
    if (o_underrun !== EXP_UNDERRUN) begin
      n_fail++;
      $display("[TB] FAIL underrun_sticky: got %b, expected %b", o_underrun, EXP_UNDERRUN);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] got, exp_byte;
    logic rdy;
    int base = pull_count;
    push_word(32'hDEADBEEF);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(2, 6, got, rdy);
      exp_byte = next_exp();
      n_cmp++;
      if (rdy !== 1'b1 || got !== exp_byte) begin
        n_fail++;
        $display("[TB] FAIL midreset_byte%0d: got %h ready=%b, expected %h ready=1", k, got, rdy, exp_byte);
      end
    end
    exp_q.delete();
    push_word(32'h11223344);
    i_reset = 1'b1;
    repeat (3) begin
      @(negedge i_clk);
      n_cmp++;
      if (o_smi_data !== 8'h00 || o_data_ready !== 1'b0 || o_fifo_pull !== 1'b0 || o_underrun !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL midreset_outputs: got data=%h ready=%b pull=%b underrun=%b, expected all 0",
                 o_smi_data, o_data_ready, o_fifo_pull, o_underrun);
      end
    end
    i_reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(3, 7, got, rdy);
      exp_byte = next_exp();
      n_cmp++;
      if (rdy !== 1'b1 || got !== exp_byte) begin
        n_fail++;
        $display("[TB] FAIL after_reset_byte%0d: got %h ready=%b, expected %h ready=1", k, got, rdy, exp_byte);
      end
    end
    n_cmp++;
    if (pull_count - base !== 2) begin
      n_fail++;
      $display("[TB] FAIL midreset_pulls: got %0d, expected 2", pull_count - base);
    end
  endtask

  task automatic test_enable_drop();
    logic [7:0] got, exp_byte;
    logic rdy;
    int base = pull_count;
    push_word(32'hCAFEF00D);
    push_word($urandom);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(2, 6, got, rdy);
      if (k == 0) i_enable = 1'b0;
      exp_byte = next_exp();
      n_cmp++;
      if (rdy !== 1'b1 || got !== exp_byte) begin
        n_fail++;
        $display("[TB] FAIL endrop_byte%0d: got %h ready=%b, expected %h ready=1", k, got, rdy, exp_byte);
      end
    end
    repeat (10) @(negedge i_clk);
    n_cmp++;
    if (pull_count - base !== 1 || o_data_ready !== 1'b0 || o_smi_data !== 8'h00 || fifo_q.size() !== 1) begin
      n_fail++;
      $display("[TB] FAIL endrop_idle: got pulls=%0d ready=%b data=%h fifo=%0d, expected 1 0 00 1",
               pull_count - base, o_data_ready, o_smi_data, fifo_q.size());
    end
    i_enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(2, 6, got, rdy);
      exp_byte = next_exp();
      n_cmp++;
      if (rdy !== 1'b1 || got !== exp_byte) begin
        n_fail++;
        $display("[TB] FAIL reenable_byte%0d: got %h ready=%b, expected %h ready=1", k, got, rdy, exp_byte);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] got, exp_byte;
    logic rdy;
    int base = pull_count;
    int total = 0;
    for (int burst = 0; burst < 4; burst++) begin
      int nw = $urandom_range(1, 4);
      for (int w = 0; w < nw; w++) push_word($urandom);
      total += nw;
      for (int k = 0; k < 4 * nw; k++) begin
        applyStimulus($urandom_range(1, 4), $urandom_range(6, 10), got, rdy);
        exp_byte = next_exp();
        n_cmp++;
        if (rdy !== 1'b1 || got !== exp_byte) begin
          n_fail++;
          $display("[TB] FAIL random_b%0d_byte%0d: got %h ready=%b, expected %h ready=1",
                   burst, k, got, rdy, exp_byte);
        end
      end
    end
    repeat (10) @(negedge i_clk);
    n_cmp++;
    if (pull_count - base !== total || pull_empty_err !== 0 || pull_b2b_err !== 0 || o_data_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL random_pulls: got pulls=%0d empty_pulls=%0d consecutive=%0d ready=%b, expected %0d 0 0 0",
               pull_count - base, pull_empty_err, pull_b2b_err, o_data_ready, total);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_underrun();
    test_reset_mid_word();
    test_enable_drop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] timeout");
  end

endmodule
